evr_trigger_filter: RTL and testbench

- Input conditioning stage between the raw active-low EVR trigger pin and psc_trigger's evr_trigger input.
- Synchronises the asynchronous pin and rejects glitches shorter than a minimum low width.
- Emits exactly one single-cycle trigger per qualified event, then enforces a hold-off window.
- Keeps saturating accept/reject counters for diagnostics.

---
 rtl/evr_trigger_filter.sv | 138 +++++++++++++
 tb/tb_evr_trigger_filter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/evr_trigger_filter.sv
// Conditions the raw active-low EVR trigger pin: synchronise, qualify a minimum low width,
// emit one pulse per event, apply hold-off, and keep saturating accept/reject counters.
module evr_trigger_filter #(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_LOW_CYCLES = 100,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 evr_trigger,
  input  logic                 enable,
  input  logic                 clear_counts,
  output logic                 trig_pulse,
  output logic                 trig_n,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] trig_count,
  output logic [CNT_WIDTH-1:0] glitch_count
);

  localparam int QW = $clog2(MIN_LOW_CYCLES + 1);
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [QW-1:0] QUAL_LAST = QW'(MIN_LOW_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES);

  typedef enum logic [2:0] {WAIT_HIGH, ARMED, QUALIFY, FIRE, HOLDOFF} state_t;

  state_t                 state, state_nxt;
  logic [QW-1:0]          qual_cnt, qual_nxt;
  logic [HW-1:0]          hold_cnt, hold_nxt;
  logic                   glitch;
  logic [SYNC_STAGES-1:0] sync_p;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic                   s;
  logic                   s_vld;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Synchroniser stage; the valid chain keeps the preset-high flops from arming the FSM
  // before a real pin sample has reached the last stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p   <= '1;
      sync_vld <= '0;
    end else begin
      sync_p   <= {sync_p[SYNC_STAGES-2:0], evr_trigger};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s     = sync_p[SYNC_STAGES-1];
  assign s_vld = sync_vld[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    qual_nxt  = qual_cnt;
    hold_nxt  = hold_cnt;
    glitch    = 1'b0;
    case (state)
      WAIT_HIGH: begin
        if (enable && s && s_vld) state_nxt = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_nxt = WAIT_HIGH;
        end else if (!s) begin
          if (MIN_LOW_CYCLES == 1) begin
            state_nxt = FIRE;
          end else begin
            state_nxt = QUALIFY;
            qual_nxt  = QW'(1);
          end
        end
      end
      QUALIFY: begin
        if (!enable) begin
          state_nxt = WAIT_HIGH;
        end else if (s) begin
          glitch    = 1'b1;
          state_nxt = ARMED;
        end else if (qual_cnt == QUAL_LAST) begin
          state_nxt = FIRE;
        end else begin
          qual_nxt = qual_cnt + 1'b1;
        end
      end
      FIRE: begin
        if (HOLDOFF_CYCLES == 0) begin
          state_nxt = WAIT_HIGH;
        end else begin
          state_nxt = HOLDOFF;
          hold_nxt  = HW'(1);
        end
      end
      HOLDOFF: begin
        if (!enable || hold_cnt == HOLD_LAST) state_nxt = WAIT_HIGH;
        else hold_nxt = hold_cnt + 1'b1;
      end
      default: state_nxt = WAIT_HIGH;
    endcase
  end

  // State and output stage; outputs are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_HIGH;
      qual_cnt   <= '0;
      hold_cnt   <= '0;
      trig_pulse <= 1'b0;
      trig_n     <= 1'b1;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      qual_cnt   <= qual_nxt;
      hold_cnt   <= hold_nxt;
      trig_pulse <= (state_nxt == FIRE);
      trig_n     <= (state_nxt != FIRE);
      busy       <= (state_nxt != ARMED);
    end
  end

  // Counter stage; a clear overrides any increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_count   <= '0;
      glitch_count <= '0;
    end else if (clear_counts) begin
      trig_count   <= '0;
      glitch_count <= '0;
    end else begin
      if (state == FIRE) trig_count <= sat_inc(trig_count);
      if (glitch) glitch_count <= sat_inc(glitch_count);
    end
  end

endmodule

// File: tb/tb_evr_trigger_filter.sv
// Directed bench for evr_trigger_filter: a default-parameter instance plus a small
// instance (MIN_LOW_CYCLES=3, HOLDOFF_CYCLES=4, CNT_WIDTH=2) for saturation.
module tb_evr_trigger_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        evr_trigger = 1'b1;
  logic        evr_trigger2 = 1'b1;
  logic        enable = 1'b0;
  logic        clear_counts = 1'b0;
  logic        trig_pulse, trig_n, busy;
  logic [15:0] trig_count, glitch_count;
  logic        trig_pulse2, trig_n2, busy2;
  logic [1:0]  trig_count2, glitch_count2;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int p0;
  int n;

  evr_trigger_filter dut (
    .clk(clk), .reset(reset), .evr_trigger(evr_trigger), .enable(enable),
    .clear_counts(clear_counts), .trig_pulse(trig_pulse), .trig_n(trig_n), .busy(busy),
    .trig_count(trig_count), .glitch_count(glitch_count)
  );

  evr_trigger_filter #(
    .SYNC_STAGES(2), .MIN_LOW_CYCLES(3), .HOLDOFF_CYCLES(4), .CNT_WIDTH(2)
  ) dut_small (
    .clk(clk), .reset(reset), .evr_trigger(evr_trigger2), .enable(enable),
    .clear_counts(clear_counts), .trig_pulse(trig_pulse2), .trig_n(trig_n2), .busy(busy2),
    .trig_count(trig_count2), .glitch_count(glitch_count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (trig_pulse) pulse_cnt <= pulse_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget) begin
      @(posedge clk);
      #1;
      cnt++;
      if (trig_pulse) break;
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_pulse", trig_pulse, 0);
    chk("rst_trig_n", trig_n, 1);
    chk("rst_busy", busy, 1);
    chk("rst_tc", trig_count, 0);
    chk("rst_gc", glitch_count, 0);
    chk("rst_trig_n2", trig_n2, 1);
    chk("rst_busy2", busy2, 1);
    reset = 1'b0;
    enable = 1'b1;
    cyc(10);
    chk("armed_busy", busy, 0);

    // clean event: 2 sync edges + 100 qualifying samples
    p0 = pulse_cnt;
    evr_trigger = 1'b0;
    wait_pulse(200, n);
    chk("clean_latency", n, 102);
    chk("clean_trig_n_low", trig_n, 0);
    chk("clean_tc_in_fire", trig_count, 0);
    cyc(1);
    chk("clean_pulse_1cyc", trig_pulse, 0);
    chk("clean_trig_n_high", trig_n, 1);
    chk("clean_tc", trig_count, 1);
    chk("clean_busy_holdoff", busy, 1);
    cyc(497);
    evr_trigger = 1'b1;
    cyc(700);
    chk("clean_pulses", pulse_cnt - p0, 1);
    chk("clean_gc", glitch_count, 0);
    chk("clean_rearmed", busy, 0);

    // 50-cycle glitch
    p0 = pulse_cnt;
    evr_trigger = 1'b0;
    cyc(50);
    chk("glitch_busy_qualify", busy, 1);
    evr_trigger = 1'b1;
    cyc(10);
    chk("glitch_pulses", pulse_cnt - p0, 0);
    chk("glitch_gc", glitch_count, 1);
    chk("glitch_busy", busy, 0);

    // two pulses 500 cycles apart: second lands in hold-off
    p0 = pulse_cnt;
    evr_trigger = 1'b0; cyc(200);
    evr_trigger = 1'b1; cyc(300);
    evr_trigger = 1'b0; cyc(200);
    evr_trigger = 1'b1; cyc(1100);
    chk("holdoff_near_pulses", pulse_cnt - p0, 1);
    chk("holdoff_near_tc", trig_count, 2);
    chk("holdoff_near_gc", glitch_count, 1);

    // two pulses 1500 cycles apart: both fire
    p0 = pulse_cnt;
    evr_trigger = 1'b0; cyc(200);
    evr_trigger = 1'b1; cyc(1300);
    evr_trigger = 1'b0; cyc(200);
    evr_trigger = 1'b1; cyc(1100);
    chk("holdoff_far_pulses", pulse_cnt - p0, 2);
    chk("holdoff_far_tc", trig_count, 4);

    // pin stuck low through reset release
    evr_trigger = 1'b0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    p0 = pulse_cnt;
    cyc(300);
    chk("stuck_pulses", pulse_cnt - p0, 0);
    chk("stuck_busy", busy, 1);
    chk("stuck_tc", trig_count, 0);
    evr_trigger = 1'b1;
    cyc(10);
    chk("stuck_armed", busy, 0);
    evr_trigger = 1'b0; cyc(150);
    evr_trigger = 1'b1; cyc(1100);
    chk("stuck_then_fire_pulses", pulse_cnt - p0, 1);
    chk("stuck_then_fire_tc", trig_count, 1);

    // enable dropped mid-qualification
    p0 = pulse_cnt;
    evr_trigger = 1'b0;
    cyc(52);
    enable = 1'b0;
    cyc(60);
    chk("en_drop_pulses", pulse_cnt - p0, 0);
    chk("en_drop_gc", glitch_count, 0);
    chk("en_drop_busy", busy, 1);
    evr_trigger = 1'b1;
    enable = 1'b1;
    cyc(10);
    chk("en_restore_busy", busy, 0);
    chk("en_restore_gc", glitch_count, 0);

    // clear coincident with FIRE
    evr_trigger = 1'b0;
    wait_pulse(200, n);
    chk("clr_fire_seen", trig_pulse, 1);
    chk("clr_tc_before", trig_count, 1);
    clear_counts = 1'b1;
    cyc(1);
    clear_counts = 1'b0;
    chk("clr_tc_after", trig_count, 0);
    evr_trigger = 1'b1;
    cyc(1100);

    // async reset between edges during hold-off
    evr_trigger = 1'b0; cyc(50);
    evr_trigger = 1'b1; cyc(10);
    chk("pre_rst_gc", glitch_count, 1);
    evr_trigger = 1'b0;
    wait_pulse(200, n);
    chk("pre_rst_latency", n, 102);
    cyc(50);
    chk("pre_rst_tc", trig_count, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_pulse", trig_pulse, 0);
    chk("arst_trig_n", trig_n, 1);
    chk("arst_busy", busy, 1);
    chk("arst_tc", trig_count, 0);
    chk("arst_gc", glitch_count, 0);
    evr_trigger = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(5);

    // small instance: latency, then saturation of both counters
    n = 0;
    evr_trigger2 = 1'b0;
    while (n < 20 && !trig_pulse2) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("small_latency", n, 5);
    chk("small_trig_n", trig_n2, 0);
    cyc(2);
    evr_trigger2 = 1'b1;
    cyc(10);
    repeat (4) begin
      evr_trigger2 = 1'b0; cyc(6);
      evr_trigger2 = 1'b1; cyc(10);
    end
    chk("sat_tc", trig_count2, 3);
    chk("sat_gc_before", glitch_count2, 0);
    repeat (4) begin
      evr_trigger2 = 1'b0; cyc(2);
      evr_trigger2 = 1'b1; cyc(5);
    end
    chk("sat_gc", glitch_count2, 3);
    chk("sat_tc_hold", trig_count2, 3);
    chk("sat_busy", busy2, 0);
    clear_counts = 1'b1;
    cyc(1);
    clear_counts = 1'b0;
    chk("sat_clr_tc", trig_count2, 0);
    chk("sat_clr_gc", glitch_count2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
